// File: rtl/bus_map_pkg.sv
// Bus address map shared by the memory responder and CPU test programs:
// I/O page register offsets, STATUS bit layout and the data width.
package bus_map_pkg;

    localparam int unsigned DATA_W = 16;

    typedef enum logic [7:0] {
        IO_TXDATA = 8'h00,
        IO_STATUS = 8'h01,
        IO_TIMER  = 8'h02,
        IO_TCTRL  = 8'h03
    } io_reg_e;

    localparam int unsigned ST_OVF   = 15;
    localparam int unsigned ST_TWRAP = 14;
    localparam int unsigned ST_FULL  = 11;
    localparam int unsigned ST_EMPTY = 10;

    function automatic logic [DATA_W-1:0] pack_status(input logic ovf, input logic twrap,
                                                      input logic full, input logic empty,
                                                      input logic [3:0] count);
        logic [DATA_W-1:0] s;
        s           = '0;
        s[ST_OVF]   = ovf;
        s[ST_TWRAP] = twrap;
        s[ST_FULL]  = full;
        s[ST_EMPTY] = empty;
        s[3:0]      = count;
        return s;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO, power-of-two depth up to 8. A push while full is only
// accepted when a pop happens in the same cycle; head reads 0 when empty.
module sync_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [3:0]       count
);

    localparam int unsigned PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]  DEPTH_C = 4'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [3:0]       cnt;
    logic             do_push, do_pop;

    assign full    = (cnt == DEPTH_C);
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rd_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 4'd1;
                2'b01:   cnt <= cnt - 4'd1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/bus_memory_responder.sv
// CPU bus target: 256x16 RAM with asynchronous read plus an I/O page holding
// an output FIFO, a free-running 16-bit timer and a status register.
module bus_memory_responder
    import bus_map_pkg::*;
#(
    parameter int unsigned RAM_AW     = 8,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [15:0] IO_BASE    = 16'hFF00
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [15:0]       Address,
    input  logic [DATA_W-1:0] D_out,
    input  logic              mw_en,
    output logic [DATA_W-1:0] D_in,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready
);

    logic [DATA_W-1:0] ram [2**RAM_AW];
    logic [DATA_W-1:0] timer;
    logic              tmr_en, ovf, twrap;
    logic              io_sel, wr_tx, wr_status, wr_timer, wr_tctrl;
    logic              fifo_full, fifo_empty, pop, wrap_evt;
    logic [3:0]        fifo_count;
    logic [7:0]        io_off;

    assign io_sel    = (Address[15:8] == IO_BASE[15:8]);
    assign io_off    = Address[7:0];
    assign wr_tx     = mw_en && io_sel && (io_off == IO_TXDATA);
    assign wr_status = mw_en && io_sel && (io_off == IO_STATUS);
    assign wr_timer  = mw_en && io_sel && (io_off == IO_TIMER);
    assign wr_tctrl  = mw_en && io_sel && (io_off == IO_TCTRL);
    assign pop       = out_valid && out_ready;
    assign out_valid = !fifo_empty;
    assign wrap_evt  = tmr_en && !wr_timer && (timer == '1);

    sync_fifo #(
        .DEPTH(FIFO_DEPTH),
        .WIDTH(DATA_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .push    (wr_tx),
        .pop     (pop),
        .wr_data (D_out),
        .rd_data (out_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (mw_en && !io_sel) ram[Address[RAM_AW-1:0]] <= D_out;
    end

    // Sticky flags: the set is written last so it wins over a same-cycle clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timer  <= '0;
            tmr_en <= 1'b0;
            ovf    <= 1'b0;
            twrap  <= 1'b0;
        end else begin
            if (wr_timer)    timer <= D_out;
            else if (tmr_en) timer <= timer + DATA_W'(1);
            if (wr_tctrl) tmr_en <= D_out[0];
            if (wr_status && D_out[ST_OVF])   ovf   <= 1'b0;
            if (wr_status && D_out[ST_TWRAP]) twrap <= 1'b0;
            if (wr_tx && fifo_full && !pop)   ovf   <= 1'b1;
            if (wrap_evt)                     twrap <= 1'b1;
        end
    end

    always_comb begin
        D_in = '0;
        if (io_sel) begin
            case (io_off)
                IO_STATUS: D_in = pack_status(ovf, twrap, fifo_full, fifo_empty, fifo_count);
                IO_TIMER:  D_in = timer;
                IO_TCTRL:  D_in = {{(DATA_W-1){1'b0}}, tmr_en};
                default:   D_in = '0;
            endcase
        end else begin
            D_in = ram[Address[RAM_AW-1:0]];
        end
    end

endmodule
